// File: rtl/mem_responder.sv
// Word-addressed memory responder with a req/ready handshake and a fixed
// number of wait states; byte-enabled writes and misaligned/out-of-range errors.
module mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } xfer_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    xfer_t       xfer_q, xfer_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          bad;
    logic          wr_en;

    // A request may be taken on the edge that closes the RESP cycle, so a
    // requester holding req sees one response every LATENCY+1 cycles.
    assign accept     = req && (state_q == IDLE || state_q == RESP);
    assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
    assign offset     = xfer_q.addr - BASE_ADDR;
    assign idx        = offset[AW+1:2];
    assign bad        = (xfer_q.addr[1:0] != 2'b00) || (offset >= SPAN);
    assign wr_en      = enter_resp && xfer_q.we && !bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = req ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == RESP);
        err   = (state_q == RESP) && err_q;
        rdata = rdata_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        xfer_d  = xfer_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d  = CNT_INIT;
            xfer_d = '{we: we, addr: addr, wdata: wdata, be: be};
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (enter_resp) begin
            err_d   = bad;
            rdata_d = (!xfer_q.we && !bad) ? mem[idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            xfer_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            xfer_q  <= xfer_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (xfer_q.be[i]) mem[idx][8*i +: 8] <= xfer_q.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 15) share one request bus,
// each with its own req line and response outputs.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v [3];
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        err_v [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]));
    mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]));
    mem_responder #(.LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on responder k; lat counts edges after the acceptance
    // edge until ready is seen (-1 if it never comes).
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic [31:0] rd, output logic e);
        int n;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b; req_v[k] = 1'b1;
        @(posedge clk);
        n = 0; lat = -1;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (ready_v[k]) begin lat = n; break; end
        end
        rd = rdata_v[k]; e = err_v[k]; req_v[k] = 1'b0;
    endtask

    task automatic gap(input int k, output int first, output int period);
        int p1, p2;
        p1 = -1; p2 = -1;
        @(negedge clk);
        we = 1'b0; addr = 32'h10; be = 4'hF; req_v[k] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ready_v[k]) begin
                if (p1 < 0) p1 = i;
                else if (p2 < 0) p2 = i;
            end
        end
        req_v[k] = 1'b0;
        repeat (4) @(posedge clk);
        first = p1; period = p2 - p1;
    endtask

    initial begin
        int lat, first, period, n;
        logic [31:0] rd;
        logic e;
        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0;
        for (int k = 0; k < 3; k++) req_v[k] = 1'b0;
        #2 reset = 1'b0;
        #10;
        chk("rst_ready", 32'(ready_v[0]), 0);
        chk("rst_err", 32'(err_v[0]), 0);
        chk("rst_rdata", rdata_v[0], 0);
        @(negedge clk) reset = 1'b1;

        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
        chk("wr10_lat", 32'(lat), 2);
        chk("wr10_err", 32'(e), 0);
        chk("wr10_rdata", rd, 0);
        txn(0, 0, 32'h10, 32'h0, 4'hF, lat, rd, e);
        chk("rd10_lat", 32'(lat), 2);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_err", 32'(e), 0);
        repeat (3) @(posedge clk); #1;
        chk("hold_ready", 32'(ready_v[0]), 0);
        chk("hold_rdata", rdata_v[0], 32'hDEADBEEF);

        txn(0, 1, 32'h20, 32'h11223344, 4'hF, lat, rd, e);
        txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, e);
        txn(0, 0, 32'h20, 32'h0, 4'hF, lat, rd, e);
        chk("be0101_data", rd, 32'h11BB33DD);
        txn(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, e);
        chk("be0000_lat", 32'(lat), 2);
        chk("be0000_err", 32'(e), 0);
        txn(0, 0, 32'h20, 32'h0, 4'hF, lat, rd, e);
        chk("be0000_data", rd, 32'h11BB33DD);

        txn(0, 0, 32'h13, 32'h0, 4'hF, lat, rd, e);
        chk("misal_err", 32'(e), 1);
        chk("misal_rdata", rd, 0);
        @(posedge clk); #1;
        chk("err_clear", 32'(err_v[0]), 0);
        chk("ready_clear", 32'(ready_v[0]), 0);

        txn(0, 1, 32'h0, 32'h01020304, 4'hF, lat, rd, e);
        txn(0, 1, 32'h3FC, 32'h5A5A5A5A, 4'hF, lat, rd, e);
        txn(0, 1, 32'h400, 32'h12345678, 4'hF, lat, rd, e);
        chk("oor_err", 32'(e), 1);
        txn(0, 0, 32'h3FC, 32'h0, 4'hF, lat, rd, e);
        chk("oor_wordff", rd, 32'h5A5A5A5A);
        txn(0, 0, 32'h0, 32'h0, 4'hF, lat, rd, e);
        chk("oor_word0", rd, 32'h01020304);

        gap(0, first, period);
        chk("l2_first", 32'(first), 2);
        chk("l2_period", 32'(period), 3);

        txn(1, 1, 32'h10, 32'h13579BDF, 4'hF, lat, rd, e);
        chk("l1_wr_lat", 32'(lat), 1);
        txn(1, 0, 32'h10, 32'h0, 4'hF, lat, rd, e);
        chk("l1_rd_lat", 32'(lat), 1);
        chk("l1_rd_data", rd, 32'h13579BDF);
        gap(1, first, period);
        chk("l1_period", 32'(period), 2);

        txn(2, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
        chk("l15_wr_lat", 32'(lat), 15);
        txn(2, 1, 32'h20, 32'h55AA55AA, 4'hF, lat, rd, e);
        @(negedge clk);
        we = 1'b0; addr = 32'h10; be = 4'hF; req_v[2] = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 addr = 32'h20; we = 1'b1; wdata = 32'h0; req_v[2] = 1'b0;
        n = 3;
        while (n < 40 && !ready_v[2]) begin @(posedge clk); #1; n++; end
        chk("l15_mid_lat", 32'(n), 15);
        chk("l15_mid_data", rdata_v[2], 32'hDEADBEEF);
        txn(2, 0, 32'h20, 32'h0, 4'hF, lat, rd, e);
        chk("l15_nowrite", rd, 32'h55AA55AA);

        txn(0, 1, 32'h40, 32'h0BADCAFE, 4'hF, lat, rd, e);
        txn(0, 0, 32'h40, 32'h0, 4'hF, lat, rd, e);
        chk("pre_rst_data", rd, 32'h0BADCAFE);
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'hF; req_v[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) begin reset = 1'b0; req_v[0] = 1'b0; end
        #1;
        chk("midrst_ready", 32'(ready_v[0]), 0);
        chk("midrst_err", 32'(err_v[0]), 0);
        chk("midrst_rdata", rdata_v[0], 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txn(0, 0, 32'h40, 32'h0, 4'hF, lat, rd, e);
        chk("midrst_keep", rd, 32'h0BADCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
